// File: rtl/vend_sequencer.sv
// ---------------------------------------------------------------------------
// vend_sequencer
// Coin-operated vending sequencer for four items priced in 5-rupee units.
// A one-hot selection opens a purchase, coins build credit, and the item is
// dispensed once credit covers the price. Any remainder, a cancel or an
// inactivity timeout returns change as one pulse per 5-rupee coin.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   item_no    one-hot item select (0001..1000 = item1..item4)
//   sel_valid  one-cycle pulse, latches item_no (honoured in IDLE only)
//   five_rup   one-cycle pulse, 5-rupee coin inserted
//   ten_rup    one-cycle pulse, 10-rupee coin inserted
//   cancel     one-cycle pulse, abort purchase and refund (COLLECT only)
//   restock    one-cycle pulse, reload all stock counters (IDLE only)
//   product    registered dispense pulse, high during the DISPENSE cycle
//   change     registered pulse, one per 5-rupee coin returned
//   sold_out   registered pulse after a selection of an empty item
//   busy       registered, high whenever the state is not IDLE
//   credit     current credit in 5-rupee units
// ---------------------------------------------------------------------------
module vend_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned STOCK_INIT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] item_no,
  input  logic       sel_valid,
  input  logic       five_rup,
  input  logic       ten_rup,
  input  logic       cancel,
  input  logic       restock,
  output logic       product,
  output logic       change,
  output logic       sold_out,
  output logic       busy,
  output logic [2:0] credit
);

  localparam int unsigned NUM_ITEMS = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned CRED_W    = 3;
  localparam int unsigned STOCK_W   = 4;
  localparam int unsigned TMO_W     = 8;

  localparam logic [CRED_W-1:0]  CREDIT_MAX = CRED_W'(6);
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  // Registered state
  state_t                               r_state;
  logic [IDX_W-1:0]                     r_item;
  logic [CRED_W-1:0]                    r_price;
  logic [CRED_W-1:0]                    r_credit;
  logic [TMO_W-1:0]                     r_tmo;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]    r_stock;
  logic                                 r_product;
  logic                                 r_change;
  logic                                 r_sold_out;
  logic                                 r_busy;

  // Next-state values
  state_t                               w_next;
  logic [IDX_W-1:0]                     w_item_nxt;
  logic [CRED_W-1:0]                    w_price_nxt;
  logic [CRED_W-1:0]                    w_credit_nxt;
  logic [TMO_W-1:0]                     w_tmo_nxt;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]    w_stock_nxt;
  logic                                 w_sold_nxt;

  // Selection decode and coin arithmetic
  logic                                 w_sel_ok;
  logic [IDX_W-1:0]                     w_sel_idx;
  logic [CRED_W-1:0]                    w_sel_price;
  logic                                 w_coin;
  logic [CRED_W-1:0]                    w_coin_inc;
  logic [CRED_W:0]                      w_sum_wide;
  logic [CRED_W-1:0]                    w_credit_sum;
  logic                                 w_timeout;

  // One-hot decode of item_no; anything else is not a legal selection
  always_comb begin
    w_sel_ok  = 1'b1;
    w_sel_idx = '0;
    case (item_no)
      4'b0001: w_sel_idx = IDX_W'(0);
      4'b0010: w_sel_idx = IDX_W'(1);
      4'b0100: w_sel_idx = IDX_W'(2);
      4'b1000: w_sel_idx = IDX_W'(3);
      default: w_sel_ok  = 1'b0;
    endcase
    // Prices run 2,3,4,5 units for items 1..4
    w_sel_price = CRED_W'(w_sel_idx) + CRED_W'(2);
  end

  // Coin value: five_rup wins when both coins arrive together
  always_comb begin
    w_coin     = five_rup | ten_rup;
    w_coin_inc = five_rup ? CRED_W'(1) : (ten_rup ? CRED_W'(2) : CRED_W'(0));
    w_sum_wide = {1'b0, r_credit} + {1'b0, w_coin_inc};
    // Saturate so credit can never pass 6 even on an unexpected path
    w_credit_sum = (w_sum_wide > {1'b0, CREDIT_MAX}) ? CREDIT_MAX
                                                     : w_sum_wide[CRED_W-1:0];
    w_timeout  = !w_coin && (r_tmo == TMO_LAST);
  end

  // Next-state and datapath update
  always_comb begin
    w_next       = r_state;
    w_item_nxt   = r_item;
    w_price_nxt  = r_price;
    w_credit_nxt = r_credit;
    w_tmo_nxt    = r_tmo;
    w_stock_nxt  = r_stock;
    w_sold_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (restock) begin
          w_stock_nxt = {NUM_ITEMS{STOCK_FULL}};
        end
        // Selection sees the stock as it stood before any same-cycle restock
        if (sel_valid && w_sel_ok) begin
          if (r_stock[w_sel_idx] != '0) begin
            w_next       = S_COLLECT;
            w_item_nxt   = w_sel_idx;
            w_price_nxt  = w_sel_price;
            w_credit_nxt = '0;
            w_tmo_nxt    = '0;
          end else begin
            w_sold_nxt = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        w_credit_nxt = w_credit_sum;
        w_tmo_nxt    = w_coin ? '0 : r_tmo + TMO_W'(1);
        // Cancel and timeout refund everything, including a same-cycle coin
        if (cancel || w_timeout) begin
          w_next = (w_credit_sum != '0) ? S_CHANGE : S_IDLE;
        end else if (w_credit_sum >= r_price) begin
          w_next = S_DISPENSE;
        end
      end

      S_DISPENSE: begin
        w_stock_nxt[r_item] = r_stock[r_item] - STOCK_W'(1);
        w_credit_nxt        = r_credit - r_price;
        w_next              = (r_credit != r_price) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        w_credit_nxt = r_credit - CRED_W'(1);
        if (r_credit <= CRED_W'(1)) begin
          w_next = S_IDLE;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; pulses are aligned with the state they mark
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_item     <= '0;
      r_price    <= '0;
      r_credit   <= '0;
      r_tmo      <= '0;
      r_stock    <= {NUM_ITEMS{STOCK_FULL}};
      r_product  <= 1'b0;
      r_change   <= 1'b0;
      r_sold_out <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_item     <= w_item_nxt;
      r_price    <= w_price_nxt;
      r_credit   <= w_credit_nxt;
      r_tmo      <= w_tmo_nxt;
      r_stock    <= w_stock_nxt;
      r_product  <= (w_next == S_DISPENSE);
      r_change   <= (w_next == S_CHANGE);
      r_sold_out <= w_sold_nxt;
      r_busy     <= (w_next != S_IDLE);
    end
  end

  assign product  = r_product;
  assign change   = r_change;
  assign sold_out = r_sold_out;
  assign busy     = r_busy;
  assign credit   = r_credit;

endmodule

// File: tb/tb_vend_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vend_sequencer
// Directed bench for vend_sequencer with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// Pulse counters sample on the falling edge.
// ---------------------------------------------------------------------------
module tb_vend_sequencer;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] item_no = 4'b0000;
  logic       sel_valid = 1'b0;
  logic       five_rup = 1'b0;
  logic       ten_rup = 1'b0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       product;
  logic       change;
  logic       sold_out;
  logic       busy;
  logic [2:0] credit;

  int n_checks = 0;
  int n_fail   = 0;
  int n_prod   = 0;
  int n_chg    = 0;
  int p0, c0;

  vend_sequencer #(.TIMEOUT_CYC(TMO), .STOCK_INIT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .item_no  (item_no),
    .sel_valid(sel_valid),
    .five_rup (five_rup),
    .ten_rup  (ten_rup),
    .cancel   (cancel),
    .restock  (restock),
    .product  (product),
    .change   (change),
    .sold_out (sold_out),
    .busy     (busy),
    .credit   (credit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (product) n_prod++;
    if (change)  n_chg++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [3:0] it);
    item_no = it; sel_valid = 1'b1;
    cyc();
    item_no = 4'b0000; sel_valid = 1'b0;
  endtask

  task automatic coin(input logic f, input logic t, input logic c);
    five_rup = f; ten_rup = t; cancel = c;
    cyc();
    five_rup = 1'b0; ten_rup = 1'b0; cancel = 1'b0;
  endtask

  task automatic pulse_restock();
    restock = 1'b1;
    cyc();
    restock = 1'b0;
  endtask

  // Wait (bounded) for the sequencer to return to IDLE
  task automatic drain(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_drain: busy=%b after %0d cycles, want 0", tag, busy, k); end
  endtask

  // Buy item1 with a single 10-rupee coin
  task automatic buy1();
    sel(4'b0001);
    coin(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (product !== 1'b1) begin n_fail++; $display("FAIL buy1_product: got %b want 1", product); end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    n_checks++;
    if (busy !== 1'b0 || credit !== 3'd0) begin n_fail++; $display("FAIL reset_state: busy=%b credit=%0d want 0/0", busy, credit); end
    n_checks++;
    if (product !== 1'b0 || change !== 1'b0 || sold_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: p=%b c=%b s=%b want 000", product, change, sold_out); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_exact_payment();
    p0 = n_prod; c0 = n_chg;
    sel(4'b0001);
    n_checks++;
    if (busy !== 1'b1 || credit !== 3'd0) begin n_fail++; $display("FAIL exact_sel: busy=%b credit=%0d want 1/0", busy, credit); end
    coin(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (product !== 1'b1 || credit !== 3'd2) begin n_fail++; $display("FAIL exact_dispense: product=%b credit=%0d want 1/2", product, credit); end
    cyc();
    n_checks++;
    if (product !== 1'b0 || busy !== 1'b0 || credit !== 3'd0) begin n_fail++; $display("FAIL exact_idle: p=%b busy=%b credit=%0d want 0/0/0", product, busy, credit); end
    cyc(); cyc();
    n_checks++;
    if (n_prod - p0 != 1 || n_chg - c0 != 0) begin n_fail++; $display("FAIL exact_counts: prod=%0d chg=%0d want 1/0", n_prod - p0, n_chg - c0); end
  endtask

  task automatic test_change();
    p0 = n_prod; c0 = n_chg;
    sel(4'b1000);
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (credit !== 3'd4 || product !== 1'b0) begin n_fail++; $display("FAIL change_partial: credit=%0d product=%b want 4/0", credit, product); end
    coin(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (product !== 1'b1 || credit !== 3'd6) begin n_fail++; $display("FAIL change_dispense: product=%b credit=%0d want 1/6", product, credit); end
    cyc();
    n_checks++;
    if (change !== 1'b1 || product !== 1'b0 || credit !== 3'd1) begin n_fail++; $display("FAIL change_pulse: c=%b p=%b credit=%0d want 1/0/1", change, product, credit); end
    cyc();
    n_checks++;
    if (change !== 1'b0 || busy !== 1'b0 || credit !== 3'd0) begin n_fail++; $display("FAIL change_end: c=%b busy=%b credit=%0d want 0/0/0", change, busy, credit); end
    cyc();
    n_checks++;
    if (n_prod - p0 != 1 || n_chg - c0 != 1) begin n_fail++; $display("FAIL change_counts: prod=%0d chg=%0d want 1/1", n_prod - p0, n_chg - c0); end
  endtask

  task automatic test_cancel();
    p0 = n_prod; c0 = n_chg;
    sel(4'b0100);
    for (int i = 0; i < 3; i++) coin(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (credit !== 3'd3) begin n_fail++; $display("FAIL cancel_credit: got %0d want 3", credit); end
    coin(1'b0, 1'b0, 1'b1);
    for (int i = 3; i > 0; i--) begin
      n_checks++;
      if (change !== 1'b1 || busy !== 1'b1 || credit !== 3'(i)) begin n_fail++; $display("FAIL cancel_pulse%0d: c=%b busy=%b credit=%0d want 1/1/%0d", i, change, busy, credit, i); end
      cyc();
    end
    n_checks++;
    if (busy !== 1'b0 || change !== 1'b0 || credit !== 3'd0) begin n_fail++; $display("FAIL cancel_end: busy=%b c=%b credit=%0d want 0/0/0", busy, change, credit); end
    n_checks++;
    if (n_prod - p0 != 0 || n_chg - c0 != 3) begin n_fail++; $display("FAIL cancel_counts: prod=%0d chg=%0d want 0/3", n_prod - p0, n_chg - c0); end
  endtask

  task automatic test_timeout();
    p0 = n_prod; c0 = n_chg;
    sel(4'b0010);
    coin(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) cyc();
    n_checks++;
    if (busy !== 1'b1 || change !== 1'b0 || credit !== 3'd1) begin n_fail++; $display("FAIL timeout_early: busy=%b c=%b credit=%0d want 1/0/1", busy, change, credit); end
    cyc();
    n_checks++;
    if (change !== 1'b1 || credit !== 3'd1) begin n_fail++; $display("FAIL timeout_refund: c=%b credit=%0d want 1/1", change, credit); end
    cyc();
    n_checks++;
    if (busy !== 1'b0 || change !== 1'b0 || credit !== 3'd0) begin n_fail++; $display("FAIL timeout_end: busy=%b c=%b credit=%0d want 0/0/0", busy, change, credit); end
    n_checks++;
    if (n_prod - p0 != 0 || n_chg - c0 != 1) begin n_fail++; $display("FAIL timeout_counts: prod=%0d chg=%0d want 0/1", n_prod - p0, n_chg - c0); end
  endtask

  task automatic test_coin_rules();
    // Coin while IDLE is ignored
    coin(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (busy !== 1'b0 || credit !== 3'd0) begin n_fail++; $display("FAIL idle_coin: busy=%b credit=%0d want 0/0", busy, credit); end
    // Non-one-hot selections are ignored
    sel(4'b0011);
    n_checks++;
    if (busy !== 1'b0 || sold_out !== 1'b0) begin n_fail++; $display("FAIL bad_sel_0011: busy=%b so=%b want 0/0", busy, sold_out); end
    sel(4'b0000);
    n_checks++;
    if (busy !== 1'b0 || sold_out !== 1'b0) begin n_fail++; $display("FAIL bad_sel_0000: busy=%b so=%b want 0/0", busy, sold_out); end
    // Both coins together: only the 5-rupee coin counts
    sel(4'b1000);
    coin(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (credit !== 3'd1) begin n_fail++; $display("FAIL coin_priority: credit=%0d want 1", credit); end
    // Coin and cancel together: coin credited, then full refund
    coin(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (change !== 1'b1 || product !== 1'b0 || credit !== 3'd3) begin n_fail++; $display("FAIL coin_cancel: c=%b p=%b credit=%0d want 1/0/3", change, product, credit); end
    drain("coin_cancel");
    // Coin reaching price with cancel: cancel wins
    p0 = n_prod;
    sel(4'b0001);
    coin(1'b1, 1'b0, 1'b0);
    coin(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (change !== 1'b1 || product !== 1'b0 || credit !== 3'd2) begin n_fail++; $display("FAIL price_cancel: c=%b p=%b credit=%0d want 1/0/2", change, product, credit); end
    drain("price_cancel");
    n_checks++;
    if (n_prod - p0 != 0) begin n_fail++; $display("FAIL price_cancel_prod: got %0d want 0", n_prod - p0); end
  endtask

  task automatic test_sold_out();
    pulse_restock();
    for (int i = 0; i < 3; i++) buy1();
    sel(4'b0001);
    n_checks++;
    if (sold_out !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL sold_out_pulse: so=%b busy=%b want 1/0", sold_out, busy); end
    cyc();
    n_checks++;
    if (sold_out !== 1'b0) begin n_fail++; $display("FAIL sold_out_width: got %b want 0", sold_out); end
    pulse_restock();
    sel(4'b0001);
    n_checks++;
    if (busy !== 1'b1 || sold_out !== 1'b0) begin n_fail++; $display("FAIL restock_accept: busy=%b so=%b want 1/0", busy, sold_out); end
    // Cancel with zero credit returns straight to IDLE without change
    coin(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (busy !== 1'b0 || change !== 1'b0) begin n_fail++; $display("FAIL zero_cancel: busy=%b c=%b want 0/0", busy, change); end
  endtask

  task automatic test_reset_midway();
    for (int i = 0; i < 3; i++) buy1();
    sel(4'b1000);
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (credit !== 3'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: credit=%0d busy=%b want 3/1", credit, busy); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (credit !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async: credit=%0d busy=%b want 0/0", credit, busy); end
    c0 = n_chg;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    n_checks++;
    if (n_chg - c0 != 0) begin n_fail++; $display("FAIL midrst_change: got %0d pulses want 0", n_chg - c0); end
    // item1 was empty before reset; reset restores its stock
    sel(4'b0001);
    n_checks++;
    if (busy !== 1'b1 || sold_out !== 1'b0) begin n_fail++; $display("FAIL midrst_stock: busy=%b so=%b want 1/0", busy, sold_out); end
    coin(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_exact_payment();
    test_change();
    test_cancel();
    test_timeout();
    test_coin_rules();
    test_sold_out();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
